// File: rtl/cl_pkg.sv
// rtl/cl_pkg.sv - shared opcodes, FSM states and field-position helpers
// Purpose: constants shared by control_logic_pipe and cl_decoder.
// Contents: opcode localparams, state enum, instruction field-position functions.
package cl_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  // Register fields sit directly below the opcode, MSB down: rd, rs1, rs2.
  function automatic int rd_lsb(input int instr_w, input int opc_w, input int reg_aw);
    return instr_w - opc_w - reg_aw;
  endfunction

  function automatic int rs1_lsb(input int instr_w, input int opc_w, input int reg_aw);
    return instr_w - opc_w - 2 * reg_aw;
  endfunction

  function automatic int rs2_lsb(input int instr_w, input int opc_w, input int reg_aw);
    return instr_w - opc_w - 3 * reg_aw;
  endfunction

endpackage

// File: rtl/cl_decoder.sv
// rtl/cl_decoder.sv - combinational opcode decoder
// Purpose: map an opcode and the zero flag to datapath control bits.
// Ports: opcode/zero_flag in; dec_opcode, reg_write, src2_imm, alu_imm,
//        jump_taken, is_halt out.
module cl_decoder
  import cl_pkg::*;
#(
  parameter int OPC_W = 4
) (
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero_flag,
  output logic [OPC_W-1:0] dec_opcode,
  output logic             reg_write,
  output logic             src2_imm,
  output logic             alu_imm,
  output logic             jump_taken,
  output logic             is_halt
);

  always_comb begin
    dec_opcode = opcode;
    reg_write  = 1'b0;
    src2_imm   = 1'b0;
    alu_imm    = 1'b0;
    jump_taken = 1'b0;
    is_halt    = 1'b0;
    case (opcode)
      OPC_W'(OP_NOP): ;
      OPC_W'(OP_ADD), OPC_W'(OP_SUB), OPC_W'(OP_AND), OPC_W'(OP_OR): reg_write = 1'b1;
      OPC_W'(OP_ADDI): begin
        reg_write = 1'b1;
        src2_imm  = 1'b1;
      end
      OPC_W'(OP_LDI): begin
        reg_write = 1'b1;
        src2_imm  = 1'b1;
        alu_imm   = 1'b1;
      end
      OPC_W'(OP_JMP): jump_taken = 1'b1;
      OPC_W'(OP_JZ):  jump_taken = zero_flag;
      OPC_W'(OP_HALT): begin
        // HALT leaves a NOP in the pipeline register.
        is_halt    = 1'b1;
        dec_opcode = '0;
      end
      default: dec_opcode = '0;
    endcase
  end

endmodule

// File: rtl/control_logic_pipe.sv
// rtl/control_logic_pipe.sv - pipelined control logic with PC, FSM and retire counter
// Purpose: fetch handshake, registered decode, same-cycle JMP/JZ resolution,
//          HALT/resume FSM and saturating retired-instruction counter.
// Ports: clk/rstn; instr_addr/instr_req/instr_i/instr_valid_i fetch side;
//        stall_i, zero_flag_i, resume_i controls; registered decode outputs;
//        halted and retired_cnt status.
module control_logic_pipe
  import cl_pkg::*;
#(
  parameter int              ADDR_W   = 8,
  parameter int              INSTR_W  = 16,
  parameter int              OPC_W    = 4,
  parameter int              REG_AW   = 3,
  parameter int              IMM_W    = 6,
  parameter int              CNT_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rstn,
  output logic [ADDR_W-1:0]  instr_addr,
  output logic               instr_req,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               instr_valid_i,
  input  logic               stall_i,
  input  logic               zero_flag_i,
  input  logic               resume_i,
  output logic               PC_select,
  output logic [ADDR_W-1:0]  Jump_addr,
  output logic               Source2_select,
  output logic               ALU_out_Select,
  output logic               RegWrite_Flag,
  output logic [IMM_W-1:0]   Immediate_Addr,
  output logic [REG_AW-1:0]  Rreg_Sig1,
  output logic [REG_AW-1:0]  Rreg_Sig2,
  output logic [REG_AW-1:0]  Wreg_Sig,
  output logic [OPC_W-1:0]   OPCODE,
  output logic               halted,
  output logic [CNT_W-1:0]   retired_cnt
);

  localparam int RD_LSB  = rd_lsb(INSTR_W, OPC_W, REG_AW);
  localparam int RS1_LSB = rs1_lsb(INSTR_W, OPC_W, REG_AW);
  localparam int RS2_LSB = rs2_lsb(INSTR_W, OPC_W, REG_AW);

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   pc;
  logic [OPC_W-1:0]    opc;
  logic [OPC_W-1:0]    dec_opcode;
  logic                dec_reg_write, dec_src2_imm, dec_alu_imm;
  logic                jump_taken, is_halt;
  logic                accept;
  logic [ADDR_W-1:0]   target;

  assign opc        = instr_i[INSTR_W-1 -: OPC_W];
  assign target     = instr_i[ADDR_W-1:0];
  assign accept     = (state == ST_RUN) & instr_valid_i & ~stall_i;
  assign instr_addr = pc;
  assign instr_req  = (state == ST_RUN);
  assign halted     = (state == ST_HALT);

  cl_decoder #(.OPC_W(OPC_W)) u_dec (
    .opcode     (opc),
    .zero_flag  (zero_flag_i),
    .dec_opcode (dec_opcode),
    .reg_write  (dec_reg_write),
    .src2_imm   (dec_src2_imm),
    .alu_imm    (dec_alu_imm),
    .jump_taken (jump_taken),
    .is_halt    (is_halt)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: state_nx = ST_RUN;
      ST_RUN:  if (accept && is_halt) state_nx = ST_HALT;
      ST_HALT: if (resume_i) state_nx = ST_RUN;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pc <= RESET_PC;
    else if (accept) pc <= jump_taken ? target : pc + ADDR_W'(1);
  end

  // Pipeline register: anything not accepted becomes an all-zero bubble.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      PC_select      <= 1'b0;
      Jump_addr      <= '0;
      Source2_select <= 1'b0;
      ALU_out_Select <= 1'b0;
      RegWrite_Flag  <= 1'b0;
      Immediate_Addr <= '0;
      Rreg_Sig1      <= '0;
      Rreg_Sig2      <= '0;
      Wreg_Sig       <= '0;
      OPCODE         <= '0;
    end else if (accept) begin
      PC_select      <= jump_taken;
      Jump_addr      <= jump_taken ? target : '0;
      Source2_select <= dec_src2_imm;
      ALU_out_Select <= dec_alu_imm;
      RegWrite_Flag  <= dec_reg_write;
      Immediate_Addr <= instr_i[IMM_W-1:0];
      Rreg_Sig1      <= instr_i[RS1_LSB +: REG_AW];
      Rreg_Sig2      <= instr_i[RS2_LSB +: REG_AW];
      Wreg_Sig       <= instr_i[RD_LSB +: REG_AW];
      OPCODE         <= dec_opcode;
    end else begin
      PC_select      <= 1'b0;
      Jump_addr      <= '0;
      Source2_select <= 1'b0;
      ALU_out_Select <= 1'b0;
      RegWrite_Flag  <= 1'b0;
      Immediate_Addr <= '0;
      Rreg_Sig1      <= '0;
      Rreg_Sig2      <= '0;
      Wreg_Sig       <= '0;
      OPCODE         <= '0;
    end
  end

  // Raw opcode is used so illegal encodings still count as retired.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) retired_cnt <= '0;
    else if (accept && (opc != '0) && (retired_cnt != {CNT_W{1'b1}}))
      retired_cnt <= retired_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_control_logic_pipe.sv
// tb/tb_control_logic_pipe.sv - scoreboard bench for control_logic_pipe
module tb_control_logic_pipe;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] instr_i = '0;
  logic        instr_valid_i = 1'b0, stall_i = 1'b0, zero_flag_i = 1'b0, resume_i = 1'b0;

  logic [7:0]  instr_addr, Jump_addr;
  logic        instr_req, PC_select, Source2_select, ALU_out_Select, RegWrite_Flag, halted;
  logic [5:0]  Immediate_Addr;
  logic [2:0]  Rreg_Sig1, Rreg_Sig2, Wreg_Sig;
  logic [3:0]  OPCODE;
  logic [15:0] retired_cnt;

  logic [7:0]  d2_addr, d2_jaddr;
  logic        d2_req, d2_psel, d2_s2, d2_ao, d2_rw, d2_halted;
  logic [5:0]  d2_imm;
  logic [2:0]  d2_r1, d2_r2, d2_w;
  logic [3:0]  d2_opc;
  logic [1:0]  d2_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  control_logic_pipe dut (
    .clk(clk), .rstn(rstn), .instr_addr(instr_addr), .instr_req(instr_req),
    .instr_i(instr_i), .instr_valid_i(instr_valid_i), .stall_i(stall_i),
    .zero_flag_i(zero_flag_i), .resume_i(resume_i), .PC_select(PC_select),
    .Jump_addr(Jump_addr), .Source2_select(Source2_select),
    .ALU_out_Select(ALU_out_Select), .RegWrite_Flag(RegWrite_Flag),
    .Immediate_Addr(Immediate_Addr), .Rreg_Sig1(Rreg_Sig1), .Rreg_Sig2(Rreg_Sig2),
    .Wreg_Sig(Wreg_Sig), .OPCODE(OPCODE), .halted(halted), .retired_cnt(retired_cnt)
  );

  control_logic_pipe #(.CNT_W(2)) dut2 (
    .clk(clk), .rstn(rstn), .instr_addr(d2_addr), .instr_req(d2_req),
    .instr_i(instr_i), .instr_valid_i(instr_valid_i), .stall_i(stall_i),
    .zero_flag_i(zero_flag_i), .resume_i(resume_i), .PC_select(d2_psel),
    .Jump_addr(d2_jaddr), .Source2_select(d2_s2), .ALU_out_Select(d2_ao),
    .RegWrite_Flag(d2_rw), .Immediate_Addr(d2_imm), .Rreg_Sig1(d2_r1),
    .Rreg_Sig2(d2_r2), .Wreg_Sig(d2_w), .OPCODE(d2_opc), .halted(d2_halted),
    .retired_cnt(d2_cnt)
  );

  typedef struct {
    logic       acc;
    logic       chk_opc;
    logic [3:0] opc;
    logic [2:0] rd, rs1, rs2;
    logic [5:0] imm;
    logic       rw, s2, ao, ps;
    logic [7:0] ja;
  } exp_t;

  exp_t sb[$];

  // Reference model state: 0 idle, 1 run, 2 halt.
  int          m_state = 0;
  logic [7:0]  m_pc = 8'h00;
  logic [15:0] m_cnt = '0;
  logic [1:0]  m_cnt2 = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  task automatic check_status();
    check("pc", instr_addr, m_pc);
    check("req", instr_req, m_state == 1);
    check("halted", halted, m_state == 2);
    check("cnt", retired_cnt, m_cnt);
    check("cnt_sat", d2_cnt, m_cnt2);
  endtask

  task automatic step(input logic [15:0] ins, input logic v, input logic st,
                      input logic zf, input logic rs);
    exp_t       e;
    exp_t       g;
    logic       acc;
    logic [3:0] op;
    instr_i = ins; instr_valid_i = v; stall_i = st; zero_flag_i = zf; resume_i = rs;
    e = '{acc: 1'b0, chk_opc: 1'b1, opc: 4'h0, rd: 3'd0, rs1: 3'd0, rs2: 3'd0,
          imm: 6'd0, rw: 1'b0, s2: 1'b0, ao: 1'b0, ps: 1'b0, ja: 8'h00};
    acc = (m_state == 1) && v && !st;
    op  = ins[15:12];
    if (acc) begin
      e.acc = 1'b1; e.opc = op;
      e.rd = ins[11:9]; e.rs1 = ins[8:6]; e.rs2 = ins[5:3]; e.imm = ins[5:0];
      case (op)
        4'h1, 4'h2, 4'h3, 4'h4: e.rw = 1'b1;
        4'h5: begin e.rw = 1'b1; e.s2 = 1'b1; end
        4'h6: begin e.rw = 1'b1; e.s2 = 1'b1; e.ao = 1'b1; end
        4'h8: begin e.ps = 1'b1; e.ja = ins[7:0]; end
        4'h9: if (zf) begin e.ps = 1'b1; e.ja = ins[7:0]; end else e.chk_opc = 1'b0;
        4'hF: e.opc = 4'h0;
        4'h0: ;
        default: e.chk_opc = 1'b0;
      endcase
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (acc) begin
      m_pc = (op == 4'h8 || (op == 4'h9 && zf)) ? ins[7:0] : m_pc + 8'd1;
      if (op != 4'h0) begin
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 2'd1;
      end
    end
    case (m_state)
      0: m_state = 1;
      1: if (acc && op == 4'hF) m_state = 2;
      2: if (rs) m_state = 1;
      default: m_state = 0;
    endcase
    g = sb.pop_front();
    if (g.chk_opc) check("opcode", OPCODE, g.opc);
    check("regwrite", RegWrite_Flag, g.rw);
    check("src2", Source2_select, g.s2);
    check("aluout", ALU_out_Select, g.ao);
    check("pcsel", PC_select, g.ps);
    if (g.ps) check("jaddr", Jump_addr, g.ja);
    if (g.acc) begin
      check("rd", Wreg_Sig, g.rd);
      check("rs1", Rreg_Sig1, g.rs1);
      check("rs2", Rreg_Sig2, g.rs2);
      check("imm", Immediate_Addr, g.imm);
    end
    check_status();
  endtask

  task automatic check_reset_outputs();
    check("rst_pc", instr_addr, 8'h00);
    check("rst_req", instr_req, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_cnt", retired_cnt, 16'h0);
    check("rst_cnt2", d2_cnt, 2'd0);
    check("rst_opcode", OPCODE, 4'h0);
    check("rst_pcsel", PC_select, 1'b0);
    check("rst_rw", RegWrite_Flag, 1'b0);
    check("rst_ctl", {Source2_select, ALU_out_Select, Immediate_Addr, Rreg_Sig1,
                      Rreg_Sig2, Wreg_Sig, Jump_addr}, 32'h0);
  endtask

  task automatic model_reset();
    m_state = 0; m_pc = 8'h00; m_cnt = '0; m_cnt2 = '0;
    sb.delete();
  endtask

  initial begin
    #7;
    check_reset_outputs();
    @(negedge clk);
    #2 rstn = 1'b1;

    // IDLE cycle: valid input must not be accepted.
    step(16'h1A5C, 1, 0, 0, 0);
    step(16'h1A5C, 1, 0, 0, 0);   // ADD at 0
    step(16'h2A5C, 1, 0, 0, 1);   // SUB at 1, resume ignored in RUN
    step(16'h5A4F, 1, 0, 0, 0);   // ADDI at 2
    check("cnt3", retired_cnt, 16'd3);
    step(16'h80F0, 1, 0, 0, 0);   // JMP at 3 -> F0
    step(16'h0000, 1, 0, 0, 0);   // NOP at F0
    step(16'h9020, 1, 0, 0, 0);   // JZ not taken
    step(16'h9020, 1, 0, 1, 0);   // JZ taken -> 20
    for (int i = 0; i < 3; i++) step(16'h1A5C, 1, 1, 0, 0);
    step(16'h6E15, 0, 0, 0, 0);   // no valid
    step(16'h6E15, 1, 0, 0, 0);   // LDI
    step(16'h8010, 1, 0, 0, 0);   // JMP -> 10
    step(16'hF000, 1, 0, 0, 0);   // HALT at 10
    step(16'h1A5C, 1, 0, 0, 0);   // ignored in HALT
    step(16'h1A5C, 1, 0, 0, 0);
    step(16'h1A5C, 1, 0, 0, 1);   // resume
    step(16'h3A5C, 1, 0, 0, 0);   // AND at 11
    step(16'h7123, 1, 0, 0, 0);   // illegal opcode, counted
    for (int i = 0; i < 4; i++) step(16'h4000 | 16'($urandom_range(0, 4095)), 1, 0, 0, 0);

    // Asynchronous reset mid-run.
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    @(negedge clk);
    #2 rstn = 1'b1;

    step(16'h0000, 1, 0, 0, 0);   // IDLE
    step(16'h80FF, 1, 0, 0, 0);   // JMP -> FF
    step(16'h1A5C, 1, 0, 0, 0);   // ADD at FF -> wraps to 00
    check("wrap", instr_addr, 8'h00);
    for (int i = 0; i < 4; i++) step(16'h2000 | 16'(i), 1, 0, 0, 0);
    check("sat", d2_cnt, 2'd3);

    if (sb.size() != 0) check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end

endmodule
